// File: rtl/receptor_medidas_pkg.sv
// Shared constants and state encoding for the 7E1 measurement frame decoder.
// Frame layout: three sensors, each "H T U #".
package receptor_medidas_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NOVE = 7'h39;
  localparam logic [6:0] ASCII_HASH = 7'h23;

  localparam int N_SENSORES         = 3;
  localparam int DIGITOS_POR_SENSOR = 3;

  typedef enum logic [3:0] {
    ESPERA     = 4'h0,
    DIGITO     = 4'h1,
    TERMINADOR = 4'h2,
    PUBLICA    = 4'h3,
    DESCARTA   = 4'h4
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim flags the last count.
// Wraps to zero when counting past M-1.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock) begin
    if (zera_s)
      q <= '0;
    else if (conta)
      q <= fim ? '0 : q + 1'b1;
  end

  assign fim = (q == N'(M - 1));

endmodule

// File: rtl/conversor_ascii_bcd.sv
// Classifies a received character as BCD digit or frame terminator.
// Purely combinational.
import receptor_medidas_pkg::*;

module conversor_ascii_bcd (
  input  logic [6:0] caractere,
  output logic [3:0] nibble,
  output logic       eh_digito,
  output logic       eh_terminador
);

  assign nibble        = caractere[3:0];
  assign eh_digito     = (caractere >= ASCII_ZERO) &&
                         (caractere <= ASCII_NOVE);
  assign eh_terminador = (caractere == ASCII_HASH);

endmodule

// File: rtl/receptor_medidas_7e1.sv
// Decodes "HTU#HTU#HTU#" frames into three BCD distances.
// RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN adds a saturating error counter.
import receptor_medidas_pkg::*;

module receptor_medidas_7e1 #(
  parameter int TIMEOUT_CICLOS = 1_000_000,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  dado_ascii,
  input  logic        dado_pronto,
  output logic [11:0] medida1,
  output logic [11:0] medida2,
  output logic [11:0] medida3,
  output logic        medidas_validas,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
`ifdef RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN
  ,
  output logic [7:0]  erros
`endif
);

  estado_t    estado;
  logic [1:0] sensor;
  logic [1:0] digito;
  logic [3:0] digs [N_SENSORES][DIGITOS_POR_SENSOR];

  logic [3:0] nibble;
  logic       eh_digito;
  logic       eh_terminador;
  logic       fim;
  logic       conta;

  conversor_ascii_bcd u_conv (
    .caractere     (dado_ascii),
    .nibble        (nibble),
    .eh_digito     (eh_digito),
    .eh_terminador (eh_terminador)
  );

  assign conta = estado inside {DIGITO, TERMINADOR, DESCARTA};

  contador_m #(
    .M (TIMEOUT_CICLOS),
    .N (TIMEOUT_BITS)
  ) u_timeout (
    .clock  (clock),
    .zera_s (dado_pronto | reset),
    .conta  (conta),
    .fim    (fim)
  );

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= ESPERA;
      sensor          <= '0;
      digito          <= '0;
      medida1         <= '0;
      medida2         <= '0;
      medida3         <= '0;
      medidas_validas <= 1'b0;
      erro_quadro     <= 1'b0;
      for (int s = 0; s < N_SENSORES; s++)
        for (int d = 0; d < DIGITOS_POR_SENSOR; d++)
          digs[s][d] <= '0;
    end else begin
      medidas_validas <= 1'b0;
      erro_quadro     <= 1'b0;
      unique case (estado)
        ESPERA, PUBLICA: begin
          if (estado == PUBLICA) begin
            medida1 <= {digs[0][0], digs[0][1], digs[0][2]};
            medida2 <= {digs[1][0], digs[1][1], digs[1][2]};
            medida3 <= {digs[2][0], digs[2][1], digs[2][2]};
            medidas_validas <= 1'b1;
          end
          // A byte here is the first digit of the next frame
          sensor <= '0;
          digito <= '0;
          estado <= ESPERA;
          if (dado_pronto) begin
            if (eh_digito) begin
              digs[0][0] <= nibble;
              digito     <= 2'd1;
              estado     <= DIGITO;
            end else begin
              erro_quadro <= 1'b1;
              estado      <= DESCARTA;
            end
          end
        end
        DIGITO: begin
          if (dado_pronto) begin
            if (eh_digito) begin
              digs[sensor][digito] <= nibble;
              if (digito == 2'd2) begin
                digito <= '0;
                estado <= TERMINADOR;
              end else begin
                digito <= digito + 2'd1;
              end
            end else begin
              erro_quadro <= 1'b1;
              estado      <= DESCARTA;
            end
          end else if (fim) begin
            erro_quadro <= 1'b1;
            estado      <= ESPERA;
          end
        end
        TERMINADOR: begin
          if (dado_pronto) begin
            if (eh_terminador && sensor == 2'd2) begin
              estado <= PUBLICA;
            end else if (eh_terminador) begin
              sensor <= sensor + 2'd1;
              digito <= '0;
              estado <= DIGITO;
            end else begin
              erro_quadro <= 1'b1;
              estado      <= DESCARTA;
            end
          end else if (fim) begin
            erro_quadro <= 1'b1;
            estado      <= ESPERA;
          end
        end
        DESCARTA: begin
          if (!dado_pronto && fim)
            estado <= ESPERA;
        end
        default: estado <= ESPERA;
      endcase
    end
  end

`ifdef RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN
  always_ff @(posedge clock) begin
    if (reset)
      erros <= '0;
    else if (erro_quadro && erros != 8'hFF)
      erros <= erros + 8'd1;
  end
`endif

endmodule

// File: tb/tb_receptor_medidas_7e1.sv
// Directed and randomized frame stimulus against a string-level frame model.
// Uses a short timeout so quiet periods stay cheap.
module tb_receptor_medidas_7e1;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  dado_ascii = '0;
  logic        dado_pronto = 1'b0;
  logic [11:0] medida1, medida2, medida3;
  logic        medidas_validas, erro_quadro;
  logic [3:0]  db_estado;
`ifdef RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN
  logic [7:0]  erros;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_val = 0;
  int n_err = 0;

  logic [11:0] exp1 = '0, exp2 = '0, exp3 = '0;
  int exp_val = 0;
  int exp_err = 0;

  receptor_medidas_7e1 #(
    .TIMEOUT_CICLOS (TO),
    .TIMEOUT_BITS   (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dado_ascii      (dado_ascii),
    .dado_pronto     (dado_pronto),
    .medida1         (medida1),
    .medida2         (medida2),
    .medida3         (medida3),
    .medidas_validas (medidas_validas),
    .erro_quadro     (erro_quadro),
    .db_estado       (db_estado)
`ifdef RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN
    ,
    .erros           (erros)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (medidas_validas) n_val++;
      if (erro_quadro)     n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [6:0] c, input int gap);
    dado_ascii  = c;
    dado_pronto = 1'b1;
    @(negedge clock);
    dado_pronto = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(7'(s[i]), gap);
  endtask

  function automatic bit frame_ok(input string s);
    if (s.len() != 12) return 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        if (s[i] != "#") return 0;
      end else if (s[i] < "0" || s[i] > "9") return 0;
    end
    return 1;
  endfunction

  function automatic logic [11:0] campo(input string s, input int k);
    logic [11:0] v = '0;
    for (int d = 0; d < 3; d++)
      v = {v[7:0], 4'(s[4*k+d] - "0")};
    return v;
  endfunction

  // Model: a whole valid frame updates; anything else is exactly one error
  task automatic model_frame(input string s);
    if (frame_ok(s)) begin
      exp1 = campo(s, 0);
      exp2 = campo(s, 1);
      exp3 = campo(s, 2);
      exp_val++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".m1"}, 32'(medida1), 32'(exp1));
    chk({tag, ".m2"}, 32'(medida2), 32'(exp2));
    chk({tag, ".m3"}, 32'(medida3), 32'(exp3));
    chk({tag, ".nval"}, n_val, exp_val);
    chk({tag, ".nerr"}, n_err, exp_err);
  endtask

  initial begin
    string s;
    string r;
    int p;
    int g;
    byte unsigned c;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.m1", 32'(medida1), 0);
    chk("rst.m2", 32'(medida2), 0);
    chk("rst.m3", 32'(medida3), 0);
    chk("rst.st", 32'(db_estado), 0);
    chk("rst.val", 32'(medidas_validas), 0);
    chk("rst.err", 32'(erro_quadro), 0);

    s = "123#045#999#";
    send_str(s, 20);
    model_frame(s);
    chk_all("f1");

    send_str("12A#", 5);
    exp_err++;
    chk("bad.st", 32'(db_estado), 4);
    chk_all("bad");
    repeat (TO + 5) @(negedge clock);
    chk("bad.quiet", 32'(db_estado), 0);
    s = "007#008#009#";
    send_str(s, 3);
    model_frame(s);
    chk_all("f2");

    send_str("123#0", 3);
    dado_ascii  = 7'h34;
    dado_pronto = 1'b1;
    @(negedge clock);
    dado_pronto = 1'b0;
    repeat (TO - 2) @(negedge clock);
    chk("to.early", n_err, exp_err);
    repeat (6) @(negedge clock);
    exp_err++;
    chk_all("to");
    chk("to.st", 32'(db_estado), 0);

    send_str("1234#", 3);
    exp_err++;
    repeat (TO + 5) @(negedge clock);
    chk_all("dig4");
    s = "560#781#902#";
    send_str(s, 2);
    model_frame(s);
    chk_all("f3");

    // back-to-back frames: byte in the publish cycle starts a new frame
    s = "314#159#265#";
    send_str(s, 0);
    model_frame(s);
    r = "271#828#182#";
    send_str(r, 0);
    model_frame(r);
    repeat (3) @(negedge clock);
    chk_all("b2b");

    send_str("123#0", 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp1 = '0; exp2 = '0; exp3 = '0;
    chk("rmid.m1", 32'(medida1), 0);
    chk("rmid.m3", 32'(medida3), 0);
    chk("rmid.st", 32'(db_estado), 0);
    s = "111#222#333#";
    send_str(s, 2);
    model_frame(s);
    repeat (2) @(negedge clock);
    chk_all("f4");

    for (int k = 0; k < 12; k++) begin
      s = "";
      for (int i = 0; i < 12; i++) begin
        c = (i % 4 == 3) ? 8'h23 : 8'(8'h30 + $urandom_range(0, 9));
        s = {s, string'(c)};
      end
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, 11);
        do c = 8'($urandom_range(0, 127));
        while ((p % 4 == 3) ? (c == 8'h23) : (c >= 8'h30 && c <= 8'h39));
        s[p] = c;
      end
      g = $urandom_range(1, 20);
      send_str(s, g);
      model_frame(s);
      repeat (frame_ok(s) ? 3 : TO + 5) @(negedge clock);
      chk_all($sformatf("rnd%0d", k));
    end

`ifdef RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      send_byte(7'h58, TO + 2);
    end
    chk("erros.sat", 32'(erros), 32'hFF);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("erros.rst", 32'(erros), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/receptor_medidas_7e1.md
Name: receptor_medidas_7E1

Overview:
- Host-side decoder for the measurement stream the sensor datapath transmits over 7E1 serial.
- Sits after an rx_serial_7E1 instance and consumes its dados_ascii/pronto byte stream.
- Parses a 12-character frame of three sensors, each sent as "H T U #": ASCII digits are {3'b011, nibble}, the terminator is '#' (7'h23).
- Rebuilds the three 12-bit BCD distances and publishes them atomically once the full frame validates.

Parameters:
- TIMEOUT_CICLOS, 1_000_000: idle clock cycles allowed between bytes inside a frame; also the line-quiet time used to resynchronise.
- TIMEOUT_BITS, 20: width of the timeout counter; must hold TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dado_ascii  in  7  received character from rx_serial_7E1.
- dado_pronto  in  1  one-cycle strobe; dado_ascii is valid in that cycle.
- medida1  out  12  sensor 1 BCD {H,T,U}.
- medida2  out  12  sensor 2 BCD.
- medida3  out  12  sensor 3 BCD.
- medidas_validas  out  1  one-cycle pulse when medida1..3 update.
- erro_quadro  out  1  one-cycle pulse on any frame error.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset values:
  - All outputs 0: medidaN=12'h000, pulses low, db_estado=ESPERA (4'h0).
  - Shadow registers, sensor index and digit index all cleared.
- Clocking: one clock domain. All registers update on the rising edge. No combinational path from dado_* to any output.
- FSM states:
  - ESPERA (0): idle at frame start; sensor=0, digit=0; timeout counter held at 0.
  - DIGITO (1): expecting a digit. On dado_pronto:
    - If dado_ascii is in 7'h30..7'h39, store the nibble dado_ascii[3:0] into shadow[sensor][11-4*digit -: 4] and increment digit.
    - After digit 2, go to TERMINADOR.
    - Any other character goes to DESCARTA with erro_quadro=1.
  - TERMINADOR (2): on dado_pronto:
    - 7'h23 with sensor<2: sensor++, digit=0, go to DIGITO.
    - 7'h23 with sensor==2: go to PUBLICA.
    - Any other character: DESCARTA with erro_quadro.
  - PUBLICA (3): one cycle. Copy shadow into medida1..3, pulse medidas_validas, return to ESPERA. A dado_pronto arriving in this cycle is consumed as digit 0 of sensor 1; the next state is DIGITO with digit=1.
  - DESCARTA (4): ignore bytes. Every dado_pronto reloads the timeout counter to 0. After TIMEOUT_CICLOS cycles with no byte, go to ESPERA with no extra error pulse.
- ESPERA behaves as DIGITO for the first byte; a valid digit moves the FSM to DIGITO.
- Timeout in DIGITO/TERMINADOR:
  - The counter resets on each dado_pronto and increments otherwise.
  - When it reaches TIMEOUT_CICLOS-1: erro_quadro=1, go to ESPERA. The partial frame is discarded and medidaN are untouched.
- Error handling: medidaN never change on error; a partially received frame never leaks to the outputs.
- Nibbles 0xA..0xF (chars ':'..'?') are errors, because the BCD source never emits them.
- Reset asserted mid-frame returns everything to the reset values in the next cycle.
- Simultaneous events: dado_pronto wins over timeout in the same cycle; the byte is processed and the counter is cleared.

Optional Feature:
- Macro: RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN.
- Defined:
  - Adds output erros  out  8, an 8-bit error count.
  - Increments once per erro_quadro pulse and saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package receptor_medidas_pkg holds:
  - ASCII_ZERO=7'h30, ASCII_NOVE=7'h39, ASCII_HASH=7'h23
  - N_SENSORES=3, DIGITOS_POR_SENSOR=3
  - 4-bit state encodings ESPERA=0, DIGITO=1, TERMINADOR=2, PUBLICA=3, DESCARTA=4
- Sub-module: conversor_ascii_bcd, purely combinational. Input 7-bit char; outputs nibble[3:0], eh_digito and eh_terminador. Instantiated once.
- The timeout counter reuses the existing contador_m (M=TIMEOUT_CICLOS, N=TIMEOUT_BITS), with zera_s driven by dado_pronto|reset and conta active in DIGITO/TERMINADOR/DESCARTA.

Test Plan:
- Reset, then "123#045#999#" with bytes 20 cycles apart -> one medidas_validas pulse; medida1=12'h123, medida2=12'h045, medida3=12'h999; erro_quadro never high.
- "12A#..." (7'h41 at position 2) -> erro_quadro pulse, state DESCARTA. After TIMEOUT_CICLOS quiet cycles, send "007#008#009#" -> medida1..3 = 12'h007/008/009.
- "123#04" then silence -> erro_quadro after TIMEOUT_CICLOS cycles; medidaN keep the previous frame's values; db_estado=0.
- "1234#..." (digit where '#' is expected) -> erro_quadro, no update; the next clean frame decodes correctly.
- Reset asserted after "123#0" -> all outputs 0 next cycle; a following full frame "111#222#333#" decodes correctly.
- With RECEPTOR_MEDIDAS_CONTADOR_ERROS_EN defined: 300 consecutive bad frames -> erros=8'hFF; reset -> erros=0.
